// File: rtl/reaction_time_state_if.sv
// Signal bundle between the reaction-time stage and the top-level game logic.
// Hand-off protocol: the stage raises out_state away from STATE_ID only after the scores have been stable for a cycle.
interface reaction_time_state_if;
  logic       en;
  logic [1:0] KEY;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic [3:0] score_c;
  logic [3:0] score_d;
  logic       go_led;
  logic [7:0] HEX0;
  logic [7:0] HEX1;
  logic [7:0] HEX2;
  logic [7:0] HEX3;
  logic [3:0] out_state;

  modport master (
    output en, KEY,
    input  score_a, score_b, score_c, score_d, go_led, HEX0, HEX1, HEX2, HEX3, out_state
  );

  modport slave (
    input  en, KEY,
    output score_a, score_b, score_c, score_d, go_led, HEX0, HEX1, HEX2, HEX3, out_state
  );
endinterface

// File: rtl/reaction_time_state.sv
// Reaction-timer measurement stage: random wait, go LED, 4-digit BCD millisecond count,
// false-start detection and hand-off request to the high-score stage.
module reaction_time_state #(
  parameter int TICK_DIV    = 50000,
  parameter int MIN_WAIT_MS = 1000,
  parameter int RAND_BITS   = 11,
  parameter int FS_HOLD_MS  = 2000,
  parameter int STATE_ID    = 3,
  parameter int NEXT_HS     = 4,
  parameter int NEXT_MENU   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reaction_time_state_if.slave  bus,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_GO, S_DONE, S_FALSE, S_ABORT
  } state_t;

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int CW = 16;
  localparam logic [15:0] FULL = 16'h9999;

  state_t          state;
  logic [1:0]      key_s1, key_s2, key_d;
  logic [1:0]      press;
  logic [15:0]     lfsr;
  logic [PW-1:0]   pre;
  logic            tick;
  logic [CW-1:0]   wait_cnt;
  logic [15:0]     score;
  logic            go_led;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low segments, bit order g..a; non-BCD codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign press = key_d & ~key_s2;
  assign tick  = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
      key_d  <= 2'b11;
      lfsr   <= 16'hACE1;
    end else begin
      key_s1 <= bus.KEY;
      key_s2 <= key_s1;
      key_d  <= key_s2;
      lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Every state change also clears the prescaler so each timed interval starts phase-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      score    <= '0;
      go_led   <= 1'b0;
      pre      <= '0;
      wait_cnt <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (!bus.en) begin
        state  <= S_IDLE;
        go_led <= 1'b0;
        if (state != S_IDLE) pre <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_ARM;
            pre   <= '0;
          end
          S_ARM: begin
            wait_cnt <= CW'(MIN_WAIT_MS) + CW'(lfsr[RAND_BITS-1:0]);
            score    <= '0;
            state    <= S_WAIT;
            pre      <= '0;
          end
          S_WAIT: begin
            if (press[0]) begin
              state    <= S_FALSE;
              score    <= FULL;
              wait_cnt <= CW'(FS_HOLD_MS);
              pre      <= '0;
            end else if (press[1]) begin
              state <= S_ABORT;
              pre   <= '0;
            end else if (tick) begin
              wait_cnt <= wait_cnt - 1'b1;
              if (wait_cnt <= CW'(1)) begin
                state  <= S_GO;
                go_led <= 1'b1;
                pre    <= '0;
              end
            end
          end
          S_GO: begin
            // Saturation hands off one cycle after 9999 lands, keeping scores stable ahead of out_state.
            if (press[0] || score == FULL) begin
              state  <= S_DONE;
              go_led <= 1'b0;
              pre    <= '0;
            end else if (press[1]) begin
              state  <= S_ABORT;
              go_led <= 1'b0;
              pre    <= '0;
            end else if (tick) begin
              score <= bcd_inc(score);
            end
          end
          S_FALSE: begin
            if (tick) begin
              wait_cnt <= wait_cnt - 1'b1;
              if (wait_cnt <= CW'(1)) begin
                state <= S_ABORT;
                pre   <= '0;
              end
            end
          end
          S_DONE, S_ABORT: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    bus.out_state = 4'(STATE_ID);
    if (bus.en) begin
      case (state)
        S_DONE:  bus.out_state = 4'(NEXT_HS);
        S_ABORT: bus.out_state = 4'(NEXT_MENU);
        default: bus.out_state = 4'(STATE_ID);
      endcase
    end
  end

  assign bus.score_a = score[3:0];
  assign bus.score_b = score[7:4];
  assign bus.score_c = score[11:8];
  assign bus.score_d = score[15:12];
  assign bus.go_led  = go_led;
  assign bus.HEX0    = {1'b1, seg7(score[3:0])};
  assign bus.HEX1    = {1'b1, seg7(score[7:4])};
  assign bus.HEX2    = {1'b1, seg7(score[11:8])};
  assign bus.HEX3    = {1'b0, seg7(score[15:12])};
  assign state_dbg   = state;

endmodule
